mla_stream_adder: RTL

//  Streaming, multi-lane, parametrised-width majority-logic adder (MLA) for image-pixel pipelines.

---
 rtl/mla_stream_adder.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mla_stream_adder.sv
// Streaming multi-lane majority-logic adder with a two-stage valid/ready pipeline and frame tracking.
// Optional macro ERRSTAT_EN adds per-frame counting of beats whose result differs from exact addition.
module mla_stream_adder #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int FRAME_LEN = 262144,
  parameter int CNT_W     = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES-1:0]       in_cin,
  input  logic [WIDTH/2-1:0]     approx_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_sum,
  output logic [LANES-1:0]       out_cout,
  output logic                   out_last,
  output logic                   frame_busy,
  output logic [CNT_W-1:0]       err_count
);

  localparam int PAIRS = WIDTH / 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (y & z) | (z & x);
  endfunction

  // Ripple of 2-bit cells; each cell is either the MLA approximation or two exact full adders.
  function automatic logic [WIDTH:0] mla_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic [PAIRS-1:0] mask);
    logic c, c_mid, w0, w1, co;
    logic [WIDTH-1:0] s;
    c = cin; c_mid = 1'b0; w0 = 1'b0; w1 = 1'b0; co = 1'b0; s = '0;
    for (int k = 0; k < PAIRS; k++) begin
      if (mask[k]) begin
        w0 = maj(a[2*k], b[2*k+1], c);
        w1 = maj(a[2*k+1], b[2*k], c);
        co = maj(a[2*k+1], b[2*k+1], c);
        s[2*k]   = maj(~c, w0, w1);
        s[2*k+1] = ~co;
      end else begin
        s[2*k]   = a[2*k] ^ b[2*k] ^ c;
        c_mid    = maj(a[2*k], b[2*k], c);
        s[2*k+1] = a[2*k+1] ^ b[2*k+1] ^ c_mid;
        co       = maj(a[2*k+1], b[2*k+1], c_mid);
      end
      c = co;
    end
    return {c, s};
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PAIRS-1:0]       mask_q, mask_d;
  logic                   rdy_en_q;
  logic                   s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [LANES*WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [LANES-1:0]       s1_cin_q, s1_cin_d;
  logic                   s2_valid_q, s2_valid_d, last_q, last_d;
  logic [LANES*WIDTH-1:0] sum_q, sum_d;
  logic [LANES-1:0]       cout_q, cout_d;
  logic                   s2_en_s, accept_s, tag_s;
  logic [WIDTH:0]         lane_res_s;
  logic [LANES*WIDTH-1:0] res_sum_s;
  logic [LANES-1:0]       res_cout_s;

  assign s2_en_s    = ~s2_valid_q | out_ready;
  assign in_ready   = rdy_en_q & (state_q != DRAIN) & (~s1_valid_q | s2_en_s);
  assign accept_s   = in_valid & in_ready;
  assign out_valid  = s2_valid_q;
  assign out_sum    = sum_q;
  assign out_cout   = cout_q;
  assign out_last   = last_q;
  assign frame_busy = (state_q != IDLE);

`ifdef ERRSTAT_EN
  logic [WIDTH:0]   exact_res_s;
  logic             mismatch_s, start_s;
  logic [CNT_W-1:0] err_q, err_d;
`endif

  // Per-lane adders on the S1 operands, plus the exact reference when error statistics are on.
  always_comb begin
    lane_res_s = '0;
    res_sum_s  = '0;
    res_cout_s = '0;
`ifdef ERRSTAT_EN
    exact_res_s = '0;
    mismatch_s  = 1'b0;
`endif
    for (int i = 0; i < LANES; i++) begin
      lane_res_s = mla_add(s1_a_q[i*WIDTH +: WIDTH], s1_b_q[i*WIDTH +: WIDTH], s1_cin_q[i], mask_q);
      res_sum_s[i*WIDTH +: WIDTH] = lane_res_s[WIDTH-1:0];
      res_cout_s[i] = lane_res_s[WIDTH];
`ifdef ERRSTAT_EN
      exact_res_s = {1'b0, s1_a_q[i*WIDTH +: WIDTH]} + {1'b0, s1_b_q[i*WIDTH +: WIDTH]}
                  + {{WIDTH{1'b0}}, s1_cin_q[i]};
      if (exact_res_s != lane_res_s) mismatch_s = 1'b1;
`endif
    end
  end

  // Frame FSM, beat counter and pipeline next-state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    tag_s      = 1'b0;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_cin_d   = s1_cin_q;
    s2_valid_d = s2_valid_q;
    last_d     = last_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          mask_d = approx_mask;
          if (FRAME_LEN == 1) begin
            state_d = DRAIN;
            cnt_d   = '0;
            tag_s   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (accept_s) begin
          if (cnt_q == LAST_CNT) begin
            state_d = DRAIN;
            cnt_d   = '0;
            tag_s   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (s2_valid_q & out_ready & last_q) state_d = IDLE;
        else state_d = DRAIN;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_last_d  = tag_s;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_cin_d   = in_cin;
    end else if (s2_en_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    // Output data is only replaced by a real beat so a bubble never disturbs a held result.
    if (s2_en_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = res_sum_s;
        cout_d = res_cout_s;
        last_d = s1_last_q;
      end else begin
        last_d = 1'b0;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mask_q     <= '0;
      rdy_en_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= '0;
      s2_valid_q <= 1'b0;
      last_q     <= 1'b0;
      sum_q      <= '0;
      cout_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      rdy_en_q   <= 1'b1;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_cin_q   <= s1_cin_d;
      s2_valid_q <= s2_valid_d;
      last_q     <= last_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
    end
  end

`ifdef ERRSTAT_EN
  assign start_s = accept_s & (state_q == IDLE);

  // Saturating count of approximate results entering S2, restarted with each frame.
  always_comb begin
    err_d = err_q;
    if (start_s) begin
      err_d = '0;
    end else if (s2_en_s && s1_valid_q && mismatch_s && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end else begin
      err_d = err_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= '0;
    else err_q <= err_d;
  end

  assign err_count = err_q;
`else
  assign err_count = {CNT_W{1'b0}};
`endif

endmodule
